// File: rtl/uart_tx_fifo_if.sv
// Write-side and transmit-side handshake bundle for uart_tx_fifo.
// The master is the CPU write path plus the serializer; the slave is the FIFO itself.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output wr_valid, wr_data, tx_ready,
    input  wr_ready, tx_valid, tx_data
  );

  modport slave (
    input  wr_valid, wr_data, tx_ready,
    output wr_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer through an output register.
// A synchronized, active-low CTS gates the loading of each new byte.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_tx_fifo_if.slave          bus_if,
  input  logic                   flush_i,
  input  logic                   overflow_clear_i,
  input  logic                   uart_cts_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // state      | meaning
  // S_EMPTY    | nothing stored, nothing presented
  // S_WAIT_CTS | bytes stored, waiting for CTS to load the output register
  // S_PRESENT  | output register holds a byte (tx_valid = 1)
  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_WAIT_CTS = 2'd1;
  localparam logic [1:0] S_PRESENT  = 2'd2;

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [1:0]             state_q, state_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   overflow_q, overflow_d;
  logic [SYNC_STAGES-1:0] cts_sync_q;

  logic cts_sync;
  logic tx_valid;
  logic tx_valid_d;
  logic push;
  logic pop;
  logic xfer;
  logic wr_drop;

  assign cts_sync = cts_sync_q[SYNC_STAGES-1];
  assign tx_valid = (state_q == S_PRESENT);
  assign xfer     = tx_valid && bus_if.tx_ready;
  assign push     = bus_if.wr_valid && wr_ready_q && !flush_i;
  assign wr_drop  = bus_if.wr_valid && !wr_ready_q && !flush_i;
  assign pop      = (level_q != '0) && !cts_sync && (!tx_valid || bus_if.tx_ready) && !flush_i;

  // Synchronizer resets high so CTS reads as deasserted until the host drives it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cts_sync_q <= '1;
    else          cts_sync_q <= {cts_sync_q[SYNC_STAGES-2:0], uart_cts_i};
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    tx_data_d = tx_data_q;
    state_d   = state_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_EMPTY:    if (level_d != '0) state_d = S_WAIT_CTS;
      S_WAIT_CTS: if (pop) state_d = S_PRESENT;
      S_PRESENT:  if (xfer && !pop) state_d = (level_d != '0) ? S_WAIT_CTS : S_EMPTY;
      default:    state_d = S_EMPTY;
    endcase

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      state_d  = S_EMPTY;
    end

    // Capacity counts the presented byte too, so full is stored + presented == DEPTH.
    tx_valid_d = (state_d == S_PRESENT);
    wr_ready_d = (level_d + LW'(tx_valid_d)) != LW'(DEPTH);
    overflow_d = wr_drop ? 1'b1 : (overflow_clear_i ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_if.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_EMPTY;
      tx_data_q  <= 8'h00;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      wr_ready_q <= wr_ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus_if.wr_ready = wr_ready_q;
  assign bus_if.tx_valid = tx_valid;
  assign bus_if.tx_data  = tx_data_q;
  assign level_o         = level_q;
  assign empty_o         = (level_q == '0) && !tx_valid;
  assign overflow_o      = overflow_q;

endmodule
